// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the subordinates on the mainbus side.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'd0,
    TransBusy   = 2'd1,
    TransNonseq = 2'd2,
    TransSeq    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    SizeByte = 3'd0,
    SizeHalf = 3'd1,
    SizeWord = 3'd2
  } hsize_t;

  localparam logic RespOkay  = 1'b0;
  localparam logic RespError = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } sub_state_t;

  // Only byte, halfword and word transfers exist on a 32-bit data bus.
  function automatic logic size_legal(input logic [2:0] size);
    return size <= 3'(SizeWord);
  endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Byte-lane strobe and alignment decode for a 32-bit AHB data bus.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] offset,
  output logic [3:0] strobe,
  output logic       misaligned
);

  always_comb begin
    strobe     = 4'b0000;
    misaligned = 1'b0;
    case (hsize)
      3'(SizeByte): strobe = 4'b0001 << offset;
      3'(SizeHalf): begin
        strobe     = offset[1] ? 4'b1100 : 4'b0011;
        misaligned = offset[0];
      end
      3'(SizeWord): begin
        strobe     = 4'b1111;
        misaligned = |offset;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_sram_sub.sv
// AHB-Lite subordinate wrapping a word-addressed SRAM with programmable wait
// states and the two-cycle ERROR response for illegal accesses.
module ahb_sram_sub
  import ahb_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DEPTH       = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA
);

  localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned       OFF_W     = IDX_W + 2;
  localparam logic [ADDR_W:0]   LIMIT     = (ADDR_W + 1)'(4 * DEPTH);
  localparam logic [3:0]        WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  sub_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OFF_W-1:0]  off_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic              legal_q;

  logic [ADDR_W-1:0] offset;
  logic              out_of_range;
  logic              misaligned;
  logic              legal;
  logic              accept;
  logic              addr_open;
  logic              take;
  logic [3:0]        addr_strobe;
  logic [3:0]        data_strobe;
  logic              data_misaligned;
  logic              wr_en;
  logic [IDX_W-1:0]  idx;
  logic              unused;

  // Below-base addresses wrap to huge offsets and fail the range check.
  assign offset       = HADDR - BASE_ADDR;
  assign out_of_range = {1'b0, offset} >= LIMIT;
  assign legal        = !out_of_range && size_legal(HSIZE) && !misaligned;
  assign accept       = HSEL && HREADY && HTRANS[1];
  assign addr_open    = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign take         = accept && addr_open;

  ahb_byte_strobe u_addr_strobe (
    .hsize      (HSIZE),
    .offset     (offset[1:0]),
    .strobe     (addr_strobe),
    .misaligned (misaligned)
  );

  ahb_byte_strobe u_data_strobe (
    .hsize      (size_q),
    .offset     (off_q[1:0]),
    .strobe     (data_strobe),
    .misaligned (data_misaligned)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q == 4'd0) state_d = StData;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StErr1: state_d = StErr2;
      default: begin
        if (accept) begin
          if (!legal) begin
            state_d = StErr1;
          end else if (WAIT_STATES > 0) begin
            state_d = StWait;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = StData;
          end
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Handshake outputs are decoded from the next state so they leave a flop.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      off_q     <= '0;
      write_q   <= 1'b0;
      size_q    <= 3'd0;
      legal_q   <= 1'b0;
      HREADYOUT <= 1'b1;
      HRESP     <= RespOkay;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        off_q   <= offset[OFF_W-1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
        legal_q <= legal;
      end
      HREADYOUT <= !((state_d == StWait) || (state_d == StErr1));
      HRESP     <= ((state_d == StErr1) || (state_d == StErr2)) ? RespError : RespOkay;
    end
  end

  logic [31:0] mem [DEPTH];

  assign idx   = off_q[OFF_W-1:2];
  assign wr_en = !HRESET && (state_q == StData) && write_q && legal_q;

  always_ff @(posedge HCLK) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (data_strobe[i]) mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA = ((state_q == StData) && !write_q) ? mem[idx] : 32'h0;

  assign unused = ^{HBURST, HTRANS[0], offset[ADDR_W-1:OFF_W], addr_strobe, data_misaligned};

endmodule

// File: tb/tb_ahb_sram_sub.sv
// Directed bench: three SRAM subordinates (0, 2 and 3 wait states) share one
// bus; tgt picks which one is selected and drives HREADY.
module tb_ahb_sram_sub;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        ro [3];
  logic        rs [3];
  logic [31:0] rd [3];
  logic        sel [3];
  logic [1:0]  tgt;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  assign sel[0] = HSEL && (tgt == 2'd0);
  assign sel[1] = HSEL && (tgt == 2'd1);
  assign sel[2] = HSEL && (tgt == 2'd2);
  assign HREADY = ro[tgt];

  ahb_sram_sub #(.ADDR_W(32), .DEPTH(256), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[0]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(ro[0]), .HRESP(rs[0]), .HRDATA(rd[0])
  );

  ahb_sram_sub #(.ADDR_W(32), .DEPTH(256), .BASE_ADDR(BASE), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[1]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(ro[1]), .HRESP(rs[1]), .HRDATA(rd[1])
  );

  ahb_sram_sub #(.ADDR_W(32), .DEPTH(256), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(sel[2]), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(ro[2]), .HRESP(rs[2]), .HRDATA(rd[2])
  );

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic [2:0] sz);
    HSEL   = s;
    HTRANS = tr;
    HADDR  = a;
    HWRITE = w;
    HSIZE  = sz;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 32'h0, 1'b0, 3'd2);
  endtask

  task automatic check(input string tag, input logic erdy, input logic eresp,
                       input logic [31:0] edata);
    total++;
    assert (ro[tgt] === erdy) else begin
      bad++;
      $error("FAIL %s hreadyout got %b want %b", tag, ro[tgt], erdy);
    end
    total++;
    assert (rs[tgt] === eresp) else begin
      bad++;
      $error("FAIL %s hresp got %b want %b", tag, rs[tgt], eresp);
    end
    total++;
    assert (rd[tgt] === edata) else begin
      bad++;
      $error("FAIL %s hrdata got %h want %h", tag, rd[tgt], edata);
    end
  endtask

  // Caller has already driven the next address phase and HWDATA.
  task automatic data_phase(input string tag, input int ws, input logic [31:0] edata);
    for (int i = 0; i < ws; i++) begin
      check(tag, 1'b0, 1'b0, 32'h0);
      cyc();
    end
    check(tag, 1'b1, 1'b0, edata);
  endtask

  task automatic err_phase(input string tag);
    check(tag, 1'b0, 1'b1, 32'h0);
    cyc();
    check(tag, 1'b1, 1'b1, 32'h0);
  endtask

  initial begin
    HRESET = 1'b1;
    HBURST = 3'd0;
    HWDATA = 32'h0;
    tgt    = 2'd0;
    idle();
    repeat (2) cyc();
    HRESET = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tgt = 2'(t);
      check("reset", 1'b1, 1'b0, 32'h0);
    end

    // Zero-wait write then back-to-back read of the same word.
    tgt = 2'd0;
    drive(1'b1, 2'd2, BASE + 32'h10, 1'b1, 3'd2);
    cyc();
    HWDATA = 32'h1234_5678;
    drive(1'b1, 2'd2, BASE + 32'h10, 1'b0, 3'd2);
    check("ws0_wr", 1'b1, 1'b0, 32'h0);
    cyc();
    idle();
    check("ws0_rd", 1'b1, 1'b0, 32'h1234_5678);
    cyc();
    check("ws0_idle", 1'b1, 1'b0, 32'h0);

    // Word 0 preset, then word/byte/halfword merge on word 4.
    drive(1'b1, 2'd2, BASE, 1'b1, 3'd2);
    cyc();
    HWDATA = 32'h600D_0000;
    drive(1'b1, 2'd2, BASE + 32'h10, 1'b1, 3'd2);
    cyc();
    HWDATA = 32'hFFFF_FFFF;
    drive(1'b1, 2'd3, BASE + 32'h11, 1'b1, 3'd0);
    cyc();
    HWDATA = 32'h0000_AB00;
    drive(1'b1, 2'd3, BASE + 32'h12, 1'b1, 3'd1);
    cyc();
    HWDATA = 32'hCDEF_0000;
    drive(1'b1, 2'd2, BASE + 32'h10, 1'b0, 3'd2);
    cyc();
    idle();
    check("merge_rd", 1'b1, 1'b0, 32'hCDEF_ABFF);
    cyc();

    // Out of range, misaligned halfword write, below base: three ERRORs.
    drive(1'b1, 2'd2, BASE + 32'h400, 1'b0, 3'd2);
    cyc();
    HWDATA = 32'hFFFF_FFFF;
    drive(1'b1, 2'd2, BASE + 32'h1, 1'b1, 3'd1);
    err_phase("err_oob");
    cyc();
    drive(1'b1, 2'd2, BASE - 32'h4, 1'b0, 3'd2);
    err_phase("err_half");
    cyc();
    drive(1'b1, 2'd2, BASE, 1'b0, 3'd2);
    err_phase("err_wrap");
    cyc();
    idle();
    check("err_after_rd", 1'b1, 1'b0, 32'h600D_0000);
    cyc();
    check("err_idle", 1'b1, 1'b0, 32'h0);

    // No-transfer cycles: IDLE, BUSY, and NONSEQ while deselected.
    HWDATA = 32'h5555_5555;
    drive(1'b1, 2'd0, BASE, 1'b1, 3'd2);
    cyc();
    check("nt_idle", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 2'd1, BASE, 1'b1, 3'd2);
    cyc();
    check("nt_busy", 1'b1, 1'b0, 32'h0);
    drive(1'b0, 2'd2, BASE, 1'b1, 3'd2);
    cyc();
    check("nt_desel", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 2'd2, BASE, 1'b0, 3'd2);
    cyc();
    idle();
    check("nt_readback", 1'b1, 1'b0, 32'h600D_0000);
    cyc();

    // Three wait states: NONSEQ/SEQ writes then NONSEQ/SEQ reads, pipelined.
    tgt = 2'd2;
    drive(1'b1, 2'd2, BASE + 32'h20, 1'b1, 3'd2);
    cyc();
    HWDATA = 32'hA5A5_0001;
    drive(1'b1, 2'd3, BASE + 32'h24, 1'b1, 3'd2);
    data_phase("ws3_wr0", 3, 32'h0);
    cyc();
    HWDATA = 32'h5A5A_0002;
    drive(1'b1, 2'd2, BASE + 32'h20, 1'b0, 3'd2);
    data_phase("ws3_wr1", 3, 32'h0);
    cyc();
    drive(1'b1, 2'd3, BASE + 32'h24, 1'b0, 3'd2);
    data_phase("ws3_rd0", 3, 32'hA5A5_0001);
    cyc();
    idle();
    data_phase("ws3_rd1", 3, 32'h5A5A_0002);
    cyc();
    check("ws3_idle", 1'b1, 1'b0, 32'h0);

    // Reset held three cycles in the middle of a waited write.
    tgt = 2'd1;
    drive(1'b1, 2'd2, BASE + 32'h30, 1'b1, 3'd2);
    cyc();
    HWDATA = 32'h1111_2222;
    idle();
    data_phase("ws2_pre", 2, 32'h0);
    cyc();
    drive(1'b1, 2'd2, BASE + 32'h30, 1'b1, 3'd2);
    cyc();
    HWDATA = 32'hDEAD_BEEF;
    idle();
    check("rst_in_wait", 1'b0, 1'b0, 32'h0);
    HRESET = 1'b1;
    repeat (3) cyc();
    check("rst_held", 1'b1, 1'b0, 32'h0);
    HRESET = 1'b0;
    cyc();
    check("rst_release", 1'b1, 1'b0, 32'h0);
    drive(1'b1, 2'd2, BASE + 32'h30, 1'b0, 3'd2);
    cyc();
    idle();
    data_phase("rst_readback", 2, 32'h1111_2222);
    cyc();
    check("final_idle", 1'b1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
